// File: rtl/seq_detect_ctrl.sv
// Streams a parallel word MSB-first into an external 10010 detector and
// collects its match results (count, first match index) with a done pulse.
//
// state | meaning
// IDLE  | waiting for a word, start_ready high
// CLEAR | detector held in reset for one cycle
// SHIFT | one word bit per cycle on j
// DRAIN | j=0 while the last detector responses arrive
// DONE  | one-cycle done pulse, results final
module seq_detect_ctrl #(
  parameter int WIDTH   = 16,
  parameter int CNT_W   = 5,
  parameter int DET_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_valid,
  output logic                     start_ready,
  input  logic [WIDTH-1:0]         din,
  output logic                     det_rst,
  output logic                     j,
  input  logic                     w,
  output logic                     busy,
  output logic [CNT_W-1:0]         match_cnt,
  output logic                     found,
  output logic [$clog2(WIDTH)-1:0] first_pos,
  output logic                     done
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int DRN_W = (DET_LAT > 1) ? $clog2(DET_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   sreg;
  logic [IDX_W-1:0]   idx;
  logic [DRN_W-1:0]   drain_cnt;
  logic               accept;
  logic               last_bit;
  logic               samp_vld;
  logic [IDX_W-1:0]   samp_idx;

  assign accept   = start_valid & start_ready;
  assign last_bit = (idx == IDX_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_CLEAR;
      S_CLEAR: state_nxt = S_SHIFT;
      S_SHIFT: if (last_bit) state_nxt = (DET_LAT == 0) ? S_DONE : S_DRAIN;
      S_DRAIN: if (drain_cnt == '0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    start_ready = rst & (state == S_IDLE);
    busy        = (state != S_IDLE);
    det_rst     = rst & (state != S_CLEAR);
    j           = (state == S_SHIFT) & sreg[WIDTH-1];
    done        = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg      <= '0;
      idx       <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        S_IDLE:  if (accept) sreg <= din;
        S_CLEAR: idx <= '0;
        S_SHIFT: begin
          sreg <= {sreg[WIDTH-2:0], 1'b0};
          idx  <= idx + IDX_W'(1);
          if (last_bit) drain_cnt <= DRN_W'((DET_LAT > 0) ? DET_LAT - 1 : 0);
        end
        S_DRAIN: if (drain_cnt != '0) drain_cnt <= drain_cnt - DRN_W'(1);
        default: ;
      endcase
    end
  end

  // Delay (SHIFT, idx) to line up with the detector's response on w
  if (DET_LAT == 0) begin : g_direct
    assign samp_vld = (state == S_SHIFT);
    assign samp_idx = idx;
  end else begin : g_pipe
    logic [DET_LAT-1:0] vld_pipe;
    logic [IDX_W-1:0]   idx_pipe [DET_LAT];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld_pipe <= '0;
        for (int i = 0; i < DET_LAT; i++) idx_pipe[i] <= '0;
      end else begin
        vld_pipe[0] <= (state == S_SHIFT);
        idx_pipe[0] <= idx;
        for (int i = 1; i < DET_LAT; i++) begin
          vld_pipe[i] <= vld_pipe[i-1];
          idx_pipe[i] <= idx_pipe[i-1];
        end
      end
    end

    assign samp_vld = vld_pipe[DET_LAT-1];
    assign samp_idx = idx_pipe[DET_LAT-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_cnt <= '0;
      found     <= 1'b0;
      first_pos <= '0;
    end else if (accept) begin
      match_cnt <= '0;
      found     <= 1'b0;
      first_pos <= '0;
    end else if (samp_vld && w) begin
      if (match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
      if (!found) begin
        found     <= 1'b1;
        first_pos <= samp_idx;
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: three instances (Moore/DET_LAT=1, Mealy/DET_LAT=0,
// Moore with 2-bit counter) each driving a behavioural 10010 detector.
module tb_seq_detect_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sv;
  logic [15:0] din;
  logic        sr [3];
  logic        bz [3];
  logic        dr [3];
  logic        jj [3];
  logic        ww [3];
  logic        dn [3];
  logic        fd [3];
  logic [3:0]  pos [3];
  logic [4:0]  cnt_a;
  logic [4:0]  cnt_b;
  logic [1:0]  cnt_c;

  int checks   = 0;
  int failures = 0;

  seq_detect_ctrl #(.WIDTH(16), .CNT_W(5), .DET_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .start_valid(sv), .start_ready(sr[0]), .din(din),
    .det_rst(dr[0]), .j(jj[0]), .w(ww[0]), .busy(bz[0]), .match_cnt(cnt_a),
    .found(fd[0]), .first_pos(pos[0]), .done(dn[0]));

  seq_detect_ctrl #(.WIDTH(16), .CNT_W(5), .DET_LAT(0)) dut_b (
    .clk(clk), .rst(rst), .start_valid(sv), .start_ready(sr[1]), .din(din),
    .det_rst(dr[1]), .j(jj[1]), .w(ww[1]), .busy(bz[1]), .match_cnt(cnt_b),
    .found(fd[1]), .first_pos(pos[1]), .done(dn[1]));

  seq_detect_ctrl #(.WIDTH(16), .CNT_W(2), .DET_LAT(1)) dut_c (
    .clk(clk), .rst(rst), .start_valid(sv), .start_ready(sr[2]), .din(din),
    .det_rst(dr[2]), .j(jj[2]), .w(ww[2]), .busy(bz[2]), .match_cnt(cnt_c),
    .found(fd[2]), .first_pos(pos[2]), .done(dn[2]));

  // Overlapping 10010 detector; state n = length of matched prefix, 5 = full match
  function automatic int det_nxt(input int s, input logic b);
    case (s)
      0: return b ? 1 : 0;
      1: return b ? 1 : 2;
      2: return b ? 1 : 3;
      3: return b ? 4 : 0;
      4: return b ? 1 : 5;
      5: return b ? 1 : 3;
      default: return 0;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_det
    int st;
    always @(posedge clk or negedge dr[g]) begin
      if (!dr[g]) st <= 0;
      else if (g == 1) st <= (det_nxt(st, jj[g]) == 5) ? 2 : det_nxt(st, jj[g]);
      else st <= det_nxt(st, jj[g]);
    end
    assign ww[g] = (g == 1) ? (st == 4 && !jj[g]) : (st == 5);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  int          dcyc [3];
  int          dcnt [3];
  logic [15:0] jword;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_word(input logic [15:0] w16);
    din = w16;
    sv  = 1'b1;
    tick();
    sv = 1'b0;
    for (int k = 0; k < 3; k++) begin
      dcyc[k] = 0;
      dcnt[k] = 0;
    end
    jword = '0;
    for (int c = 1; c <= 24; c++) begin
      for (int k = 0; k < 3; k++) if (dn[k]) begin
        dcnt[k]++;
        dcyc[k] = c;
      end
      if (c >= 2 && c <= 17) jword = {jword[14:0], jj[0]};
      tick();
    end
  endtask

  typedef struct {
    logic [15:0] din;
    int          cnt;
    int          fnd;
    int          pos;
    int          cnt_c;
  } vec_t;

  vec_t vecs [6];

  int rdy_cyc, late_rdy, cnt_at_rdy, cnt_after, busy_after, any_done;

  initial begin
    vecs[0] = '{16'h9240, 3, 1, 4, 3};
    vecs[1] = '{16'h0000, 0, 0, 0, 0};
    vecs[2] = '{16'h9249, 4, 1, 4, 3};
    vecs[3] = '{16'h4900, 2, 1, 5, 2};
    vecs[4] = '{16'h0012, 1, 1, 15, 1};
    vecs[5] = '{16'h8000, 0, 0, 0, 0};

    rst = 1'b0;
    sv  = 1'b0;
    din = '0;
    repeat (3) tick();
    chk("rst_ctrl", int'({sr[0], bz[0], dr[0], jj[0], dn[0], fd[0]}), 0);
    chk("rst_cnt", int'(cnt_a), 0);
    chk("rst_pos", int'(pos[0]), 0);
    rst = 1'b1;
    tick();
    chk("idle_ready", int'({sr[0], bz[0], dr[0]}), 3'b101);

    for (int v = 0; v < 6; v++) begin
      run_word(vecs[v].din);
      chk($sformatf("v%0d_stream", v), int'(jword), int'(vecs[v].din));
      chk($sformatf("v%0d_cnt_a", v), int'(cnt_a), vecs[v].cnt);
      chk($sformatf("v%0d_found_a", v), int'(fd[0]), vecs[v].fnd);
      chk($sformatf("v%0d_pos_a", v), int'(pos[0]), vecs[v].pos);
      chk($sformatf("v%0d_cnt_b", v), int'(cnt_b), vecs[v].cnt);
      chk($sformatf("v%0d_found_b", v), int'(fd[1]), vecs[v].fnd);
      chk($sformatf("v%0d_pos_b", v), int'(pos[1]), vecs[v].pos);
      chk($sformatf("v%0d_cnt_c", v), int'(cnt_c), vecs[v].cnt_c);
      chk($sformatf("v%0d_pos_c", v), int'(pos[2]), vecs[v].pos);
      chk($sformatf("v%0d_done_cyc_a", v), dcyc[0], 19);
      chk($sformatf("v%0d_done_cyc_b", v), dcyc[1], 18);
      chk($sformatf("v%0d_done_cyc_c", v), dcyc[2], 19);
      chk($sformatf("v%0d_done_n_a", v), dcnt[0], 1);
      chk($sformatf("v%0d_done_n_b", v), dcnt[1], 1);
    end

    // Reset during the 8th SHIFT cycle (cycle 9 after accept)
    din = 16'h9240;
    sv  = 1'b1;
    tick();
    sv = 1'b0;
    repeat (8) tick();
    chk("midrst_busy_before", int'(bz[0]), 1);
    rst = 1'b0;
    #1;
    chk("midrst_ctrl", int'({sr[0], bz[0], dr[0], jj[0], dn[0], fd[0]}), 0);
    chk("midrst_cnt", int'(cnt_a), 0);
    any_done = 0;
    for (int c = 0; c < 25; c++) begin
      if (c == 2) rst = 1'b1;
      if (dn[0] || dn[1] || dn[2]) any_done++;
      tick();
    end
    chk("midrst_no_done", any_done, 0);
    run_word(16'h9240);
    chk("after_rst_cnt_a", int'(cnt_a), 3);
    chk("after_rst_pos_a", int'(pos[0]), 4);
    chk("after_rst_done_cyc", dcyc[0], 19);

    // Back-to-back words with start_valid held high
    din = 16'h9249;
    sv  = 1'b1;
    tick();
    din = 16'h0000;
    rdy_cyc = 0;
    late_rdy = 0;
    cnt_at_rdy = -1;
    cnt_after = -1;
    busy_after = -1;
    for (int c = 1; c <= 22; c++) begin
      if (c < 20 && sr[0]) late_rdy++;
      if (sr[0] && rdy_cyc == 0) begin
        rdy_cyc = c;
        cnt_at_rdy = int'(cnt_a);
      end
      if (rdy_cyc != 0 && c == rdy_cyc + 1) begin
        cnt_after = int'(cnt_a);
        busy_after = int'(bz[0]);
      end
      tick();
    end
    sv = 1'b0;
    chk("b2b_ready_cycle", rdy_cyc, 20);
    chk("b2b_ready_while_busy", late_rdy, 0);
    chk("b2b_cnt_held", cnt_at_rdy, 4);
    chk("b2b_cnt_cleared", cnt_after, 0);
    chk("b2b_second_busy", busy_after, 1);
    repeat (25) tick();
    chk("b2b_zero_word_cnt", int'(cnt_a), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
